// File: rtl/sobel_line_scheduler.sv
// ---------------------------------------------------------------------------
// sobel_line_scheduler
//
// Packs a stream of binary Sobel edge pixels into bytes (MSB first), collects
// one image line per half of a two-line ping-pong buffer, and hands each
// completed line to a UDP sender as a packet: two header bytes carrying the
// line number, followed by LINE_BYTES payload bytes.
//
// Ports
//   clk          in   single clock for all logic
//   rst_p        in   asynchronous, active-high reset
//   sobel_valid  in   pixel strobe
//   sobel_vsync  in   frame sync, rising edge starts a frame
//   sobel        in   binary edge pixel
//   tx_ready     in   UDP sender idle
//   tx_req       in   byte pull from the UDP sender
//   tx_start     out  one-cycle packet-start pulse
//   tx_data      out  packet byte (registered)
//   tx_data_len  out  constant LINE_BYTES+2
//   tx_done      out  one-cycle pulse after the last byte is delivered
//   overflow     out  one-cycle pulse on the first pixel of a dropped line
//
// Build option
//   FRAME_END_FLAG_EN : when defined, header bit 15 marks the last line of
//                       the frame (IMAGE_HEIGHT-1); otherwise bit 15 is 0.
// ---------------------------------------------------------------------------
module sobel_line_scheduler #(
    parameter int IMAGE_WIDTH  = 1280,
    parameter int IMAGE_HEIGHT = 720,
    parameter int LINE_BYTES   = IMAGE_WIDTH / 8
) (
    input  logic        clk,
    input  logic        rst_p,
    input  logic        sobel_valid,
    input  logic        sobel_vsync,
    input  logic        sobel,
    input  logic        tx_ready,
    input  logic        tx_req,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic [15:0] tx_data_len,
    output logic        tx_done,
    output logic        overflow
);

    localparam int PW = $clog2(IMAGE_WIDTH);
    localparam int BW = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
    localparam int AW = $clog2(2 * LINE_BYTES);
    localparam logic [PW-1:0] LAST_PIX  = PW'(IMAGE_WIDTH - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(LINE_BYTES - 1);
    localparam logic [15:0]   LAST_LINE = 16'(IMAGE_HEIGHT - 1);
    localparam logic [AW-1:0] HALF_OFS  = AW'(LINE_BYTES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        HDR_H   = 3'd2,
        HDR_L   = 3'd3,
        PAYLOAD = 3'd4,
        DONE    = 3'd5
    } txState_t;

    logic              vsyncPrev_q;
    logic              vsyncRise;
    logic              frameActive_q, frameActive_d;
    logic              frameDone_q, frameDone_d;
    logic              dropLine_q, dropLine_d;
    logic              lineDrop;
    logic [PW-1:0]     pixCount_q, pixCount_d;
    logic [6:0]        shift_q, shift_d;
    logic [15:0]       lineCount_q, lineCount_d;
    logic              wrHalf_q, wrHalf_d;
    logic [1:0]        full_q, full_d;
    logic [1:0][15:0]  lineNum_q, lineNum_d;

    logic              memWe;
    logic [AW-1:0]     memAddr;
    logic [7:0]        memData;
    logic [7:0]        mem_q [2*LINE_BYTES];

    txState_t          state_q, state_d;
    logic              rdHalf_q, rdHalf_d;
    logic [BW-1:0]     byteIdx_q, byteIdx_d;
    logic [7:0]        txData_q, txData_d;
    logic [15:0]       header;
    logic [AW-1:0]     rdAddr;
    logic              releaseHalf;

    assign vsyncRise   = sobel_vsync & ~vsyncPrev_q;
    assign releaseHalf = (state_q == DONE);
    assign tx_start    = (state_q == REQ);
    assign tx_done     = (state_q == DONE);
    assign tx_data     = txData_q;
    assign tx_data_len = 16'(LINE_BYTES + 2);

    // Write side: pixel packing, line commit/drop and line numbering.
    // The DONE release is applied to full_d before the commit/drop decisions,
    // so a half freed this cycle is already seen as empty and a commit to the
    // same half lands on top of the release instead of being lost.
    always_comb begin
        frameActive_d = frameActive_q;
        frameDone_d   = frameDone_q;
        dropLine_d    = dropLine_q;
        pixCount_d    = pixCount_q;
        shift_d       = shift_q;
        lineCount_d   = lineCount_q;
        wrHalf_d      = wrHalf_q;
        full_d        = full_q;
        lineNum_d     = lineNum_q;
        lineDrop      = dropLine_q;
        overflow      = 1'b0;
        memWe         = 1'b0;
        memAddr       = (wrHalf_q ? HALF_OFS : '0) + AW'(pixCount_q >> 3);
        memData       = {shift_q, sobel};

        if (releaseHalf) begin
            full_d[rdHalf_q] = 1'b0;
        end

        if (vsyncRise) begin
            frameActive_d = 1'b1;
            frameDone_d   = 1'b0;
            dropLine_d    = 1'b0;
            pixCount_d    = '0;
            lineCount_d   = '0;
        end else if (sobel_valid && frameActive_q && !frameDone_q) begin
            shift_d = {shift_q[5:0], sobel};
            if (pixCount_q == '0 && full_d[wrHalf_q]) begin
                overflow = 1'b1;
                lineDrop = 1'b1;
            end
            dropLine_d = lineDrop;
            if (!lineDrop && pixCount_q[2:0] == 3'd7) begin
                memWe = 1'b1;
            end
            if (pixCount_q == LAST_PIX) begin
                pixCount_d = '0;
                dropLine_d = 1'b0;
                if (!lineDrop) begin
                    full_d[wrHalf_q]    = 1'b1;
                    lineNum_d[wrHalf_q] = lineCount_q;
                    wrHalf_d            = ~wrHalf_q;
                end
                if (lineCount_q == LAST_LINE) begin
                    frameDone_d = 1'b1;
                end else begin
                    lineCount_d = lineCount_q + 16'd1;
                end
            end else begin
                pixCount_d = pixCount_q + PW'(1);
            end
        end
    end

    // Write-side state register.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            vsyncPrev_q   <= 1'b0;
            frameActive_q <= 1'b0;
            frameDone_q   <= 1'b0;
            dropLine_q    <= 1'b0;
            pixCount_q    <= '0;
            shift_q       <= '0;
            lineCount_q   <= '0;
            wrHalf_q      <= 1'b0;
            full_q        <= '0;
            lineNum_q     <= '0;
        end else begin
            vsyncPrev_q   <= sobel_vsync;
            frameActive_q <= frameActive_d;
            frameDone_q   <= frameDone_d;
            dropLine_q    <= dropLine_d;
            pixCount_q    <= pixCount_d;
            shift_q       <= shift_d;
            lineCount_q   <= lineCount_d;
            wrHalf_q      <= wrHalf_d;
            full_q        <= full_d;
            lineNum_q     <= lineNum_d;
        end
    end

    // Line buffer storage; its content is only meaningful behind a full flag.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem_q[memAddr] <= memData;
        end
    end

    // TX FSM next state. Each accepted tx_req loads the next byte into the
    // output register, so the byte appears on the cycle after the request.
    always_comb begin
        state_d   = state_q;
        rdHalf_d  = rdHalf_q;
        byteIdx_d = byteIdx_q;
        txData_d  = txData_q;
        rdAddr    = (rdHalf_q ? HALF_OFS : '0) + AW'(byteIdx_q);
`ifdef FRAME_END_FLAG_EN
        header = {(lineNum_q[rdHalf_q] == LAST_LINE), lineNum_q[rdHalf_q][14:0]};
`else
        header = lineNum_q[rdHalf_q] & 16'h7FFF;
`endif
        case (state_q)
            IDLE: begin
                if (full_q[rdHalf_q] && tx_ready) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                state_d = HDR_H;
            end
            HDR_H: begin
                if (tx_req) begin
                    txData_d = header[15:8];
                    state_d  = HDR_L;
                end
            end
            HDR_L: begin
                if (tx_req) begin
                    txData_d = header[7:0];
                    state_d  = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (tx_req) begin
                    txData_d = mem_q[rdAddr];
                    if (byteIdx_q == LAST_BYTE) begin
                        state_d = DONE;
                    end else begin
                        byteIdx_d = byteIdx_q + BW'(1);
                    end
                end
            end
            DONE: begin
                rdHalf_d  = ~rdHalf_q;
                byteIdx_d = '0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // TX FSM state register.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state_q   <= IDLE;
            rdHalf_q  <= 1'b0;
            byteIdx_q <= '0;
            txData_q  <= '0;
        end else begin
            state_q   <= state_d;
            rdHalf_q  <= rdHalf_d;
            byteIdx_q <= byteIdx_d;
            txData_q  <= txData_d;
        end
    end

endmodule

// File: tb/tb_sobel_line_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sobel_line_scheduler
//
// Self-checking bench for sobel_line_scheduler with a reduced image size.
// Lines of pixels are generated here, the expected packet bytes are computed
// from the pixel values with plain arithmetic, and a monitor captures every
// byte the DUT delivers after a tx_start.
// ---------------------------------------------------------------------------
module tb_sobel_line_scheduler;

    localparam int W   = 32;
    localparam int H   = 8;
    localparam int LB  = W / 8;
    localparam int LEN = LB + 2;

    logic        clk = 1'b0;
    logic        rst_p = 1'b1;
    logic        sobel_valid = 1'b0;
    logic        sobel_vsync = 1'b0;
    logic        sobel = 1'b0;
    logic        tx_ready = 1'b0;
    logic        tx_req = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [15:0] tx_data_len;
    logic        tx_done;
    logic        overflow;

    int checks = 0;
    int failures = 0;
    int reqMode = 1;
    bit linePix[W];
    logic [7:0] byteQ[$];
    logic [7:0] expQ[$];
    bit collecting = 1'b0;
    bit skipEdge = 1'b0;
    bit reqSeen = 1'b0;
    int gotBytes = 0;
    int startCount = 0;
    int doneCount = 0;
    int ovfCount = 0;
    int holdErr = 0;
    int doneMissing = 0;
    logic [7:0] lastData = 8'h00;

    sobel_line_scheduler #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H)
    ) dut (
        .clk        (clk),
        .rst_p      (rst_p),
        .sobel_valid(sobel_valid),
        .sobel_vsync(sobel_vsync),
        .sobel      (sobel),
        .tx_ready   (tx_ready),
        .tx_req     (tx_req),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_data_len(tx_data_len),
        .tx_done    (tx_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Remember whether the sender pulled a byte at this edge; the edge that
    // ends the tx_start cycle never carries a byte.
    always @(posedge clk) begin
        reqSeen  = skipEdge ? 1'b0 : tx_req;
        skipEdge = 1'b0;
    end

    // Packet monitor: after tx_start, every pulled byte shows up on the next
    // cycle; between pulls the byte must hold; the last byte pairs with tx_done.
    always @(negedge clk) begin
        if (rst_p) begin
            collecting = 1'b0;
            gotBytes   = 0;
        end else begin
            if (tx_start) startCount++;
            if (tx_done) doneCount++;
            if (overflow) ovfCount++;
            if (collecting) begin
                if (reqSeen) begin
                    byteQ.push_back(tx_data);
                    gotBytes++;
                end else if (tx_data !== lastData) begin
                    holdErr++;
                end
                lastData = tx_data;
                if (gotBytes == LEN) begin
                    collecting = 1'b0;
                    if (tx_done !== 1'b1) doneMissing++;
                end
            end
            if (tx_start) begin
                collecting = 1'b1;
                gotBytes   = 0;
                skipEdge   = 1'b1;
                lastData   = tx_data;
            end
        end
    end

    // One clock step; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        case (reqMode)
            0:       tx_req = 1'b0;
            1:       tx_req = 1'b1;
            2:       tx_req = ~tx_req;
            default: tx_req = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic applyStimulus_vsync();
        sobel_vsync = 1'b1;
        tick();
        sobel_vsync = 1'b0;
        tick();
    endtask

    function automatic void fillLine(input int kind);
        for (int i = 0; i < W; i++) begin
            linePix[i] = (kind == 0) ? ((i % 2) == 0) : 1'($urandom_range(0, 1));
        end
    endfunction

    // Drive the pixels of linePix (the first npix of them), optionally with
    // random idle cycles carrying junk on the pixel input.
    task automatic applyStimulus_line(input bit gaps, input int npix);
        for (int i = 0; i < npix; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                sobel_valid = 1'b0;
                sobel = 1'($urandom_range(0, 1));
                tick();
            end
            sobel_valid = 1'b1;
            sobel = linePix[i];
            tick();
        end
        sobel_valid = 1'b0;
    endtask

    // Reference packet for linePix: line number header, then the pixels read
    // eight at a time as binary numbers, first pixel most significant.
    function automatic void pushExpected(input int lineNo);
        logic [15:0] hdr;
        int v;
        hdr = 16'(lineNo);
`ifdef FRAME_END_FLAG_EN
        if (lineNo == H - 1) hdr[15] = 1'b1;
`endif
        expQ.push_back(hdr[15:8]);
        expQ.push_back(hdr[7:0]);
        for (int k = 0; k < LB; k++) begin
            v = 0;
            for (int j = 0; j < 8; j++) v = v * 2 + int'(linePix[8 * k + j]);
            expQ.push_back(8'(v));
        end
    endfunction

    task automatic waitBytes(input int n, input bit whole, output bit ok);
        int cyc = 0;
        while (cyc < 3000 && (byteQ.size() < n || (whole && collecting))) begin
            tick();
            cyc++;
        end
        ok = (byteQ.size() >= n);
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({tx_start, tx_done, overflow, tx_data} !== 11'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got %b required 0", {tx_start, tx_done, overflow, tx_data});
        end
        checks++;
        if (tx_data_len !== 16'(LEN)) begin
            failures++;
            $display("[TB] FAIL reset_len got %0d required %0d", tx_data_len, LEN);
        end
        rst_p = 1'b0;
        tx_ready = 1'b1;
        reqMode = 1;
        fillLine(0);
        applyStimulus_line(1'b0, W);
        repeat (20) tick();
        checks++;
        if (startCount !== 0) begin
            failures++;
            $display("[TB] FAIL no_frame_before_vsync got %0d starts required 0", startCount);
        end
    endtask

    task automatic test_single_line();
        bit ok;
        int d0 = doneCount;
        byteQ.delete(); expQ.delete();
        reqMode = 1;
        applyStimulus_vsync();
        fillLine(0);
        applyStimulus_line(1'b0, W);
        pushExpected(0);
        checks++;
        if (tx_start !== 1'b0) begin
            failures++;
            $display("[TB] FAIL latency_early got tx_start=%b required 0", tx_start);
        end
        tick();
        checks++;
        if (tx_start !== 1'b1) begin
            failures++;
            $display("[TB] FAIL latency_start got tx_start=%b required 1", tx_start);
        end
        waitBytes(LEN, 1'b1, ok);
        checks++;
        if (!ok) begin failures++; $display("[TB] FAIL single_timeout got %0d bytes required %0d", byteQ.size(), LEN); end
        checks++;
        if (byteQ.size() !== expQ.size()) begin failures++; $display("[TB] FAIL single_count got %0d required %0d", byteQ.size(), expQ.size()); end
        foreach (expQ[i]) if (i < byteQ.size()) begin
            checks++;
            if (byteQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL single_byte%0d got %02h required %02h", i, byteQ[i], expQ[i]); end
        end
        repeat (3) tick();
        checks++;
        if (doneCount - d0 !== 1 || doneMissing !== 0) begin
            failures++;
            $display("[TB] FAIL single_done got %0d pulses (%0d misplaced) required 1", doneCount - d0, doneMissing);
        end
    endtask

    task automatic test_req_toggle();
        bit ok;
        byteQ.delete(); expQ.delete();
        reqMode = 2;
        applyStimulus_vsync();
        fillLine(0);
        applyStimulus_line(1'b0, W);
        pushExpected(0);
        waitBytes(LEN, 1'b1, ok);
        checks++;
        if (!ok || byteQ.size() !== expQ.size()) begin failures++; $display("[TB] FAIL toggle_count got %0d required %0d", byteQ.size(), expQ.size()); end
        foreach (expQ[i]) if (i < byteQ.size()) begin
            checks++;
            if (byteQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL toggle_byte%0d got %02h required %02h", i, byteQ[i], expQ[i]); end
        end
        checks++;
        if (holdErr !== 0) begin failures++; $display("[TB] FAIL toggle_hold got %0d changes required 0", holdErr); end
        reqMode = 1;
        repeat (3) tick();
    endtask

    task automatic test_random_lines();
        bit ok;
        int o0 = ovfCount;
        byteQ.delete(); expQ.delete();
        reqMode = 3;
        applyStimulus_vsync();
        for (int n = 0; n < 4; n++) begin
            fillLine(1);
            applyStimulus_line(1'b1, W);
            pushExpected(n);
        end
        waitBytes(4 * LEN, 1'b1, ok);
        checks++;
        if (!ok || byteQ.size() !== expQ.size()) begin failures++; $display("[TB] FAIL random_count got %0d required %0d", byteQ.size(), expQ.size()); end
        foreach (expQ[i]) if (i < byteQ.size()) begin
            checks++;
            if (byteQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL random_byte%0d got %02h required %02h", i, byteQ[i], expQ[i]); end
        end
        checks++;
        if (ovfCount !== o0 || holdErr !== 0) begin failures++; $display("[TB] FAIL random_clean got ovf=%0d hold=%0d required ovf=%0d hold=0", ovfCount, holdErr, o0); end
        reqMode = 1;
        repeat (3) tick();
    endtask

    task automatic test_overflow();
        bit ok;
        int o0 = ovfCount;
        int s0 = startCount;
        byteQ.delete(); expQ.delete();
        reqMode = 1;
        tx_ready = 1'b0;
        applyStimulus_vsync();
        for (int n = 0; n < 3; n++) begin
            fillLine(1);
            applyStimulus_line(1'b1, W);
            if (n < 2) pushExpected(n);
        end
        repeat (5) tick();
        checks++;
        if (ovfCount - o0 !== 1) begin failures++; $display("[TB] FAIL overflow_pulse got %0d required 1", ovfCount - o0); end
        checks++;
        if (startCount !== s0) begin failures++; $display("[TB] FAIL overflow_notready got %0d starts required 0", startCount - s0); end
        tx_ready = 1'b1;
        waitBytes(2 * LEN, 1'b1, ok);
        fillLine(1);
        applyStimulus_line(1'b1, W);
        pushExpected(3);
        waitBytes(3 * LEN, 1'b1, ok);
        checks++;
        if (!ok || byteQ.size() !== expQ.size()) begin failures++; $display("[TB] FAIL overflow_count got %0d required %0d", byteQ.size(), expQ.size()); end
        foreach (expQ[i]) if (i < byteQ.size()) begin
            checks++;
            if (byteQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL overflow_byte%0d got %02h required %02h", i, byteQ[i], expQ[i]); end
        end
        if (byteQ.size() >= 2 * LEN + 2) begin
            checks++;
            if ({byteQ[2*LEN], byteQ[2*LEN+1]} !== 16'h0003) begin
                failures++;
                $display("[TB] FAIL overflow_hdr got %04h required 0003", {byteQ[2*LEN], byteQ[2*LEN+1]});
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_vsync_discard();
        bit ok;
        int s0 = startCount;
        byteQ.delete(); expQ.delete();
        reqMode = 1;
        applyStimulus_vsync();
        for (int n = 0; n < 5; n++) begin
            fillLine(1);
            applyStimulus_line(1'b1, W);
            pushExpected(n);
        end
        fillLine(1);
        applyStimulus_line(1'b0, W / 2);
        applyStimulus_vsync();
        fillLine(1);
        applyStimulus_line(1'b1, W);
        pushExpected(0);
        waitBytes(6 * LEN, 1'b1, ok);
        repeat (5) tick();
        checks++;
        if (startCount - s0 !== 6) begin failures++; $display("[TB] FAIL discard_packets got %0d required 6", startCount - s0); end
        checks++;
        if (!ok || byteQ.size() !== expQ.size()) begin failures++; $display("[TB] FAIL discard_count got %0d required %0d", byteQ.size(), expQ.size()); end
        foreach (expQ[i]) if (i < byteQ.size()) begin
            checks++;
            if (byteQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL discard_byte%0d got %02h required %02h", i, byteQ[i], expQ[i]); end
        end
    endtask

    task automatic test_frame_saturation();
        bit ok;
        int s0 = startCount;
        logic [15:0] hdrLast;
`ifdef FRAME_END_FLAG_EN
        hdrLast = 16'h8000 | 16'(H - 1);
`else
        hdrLast = 16'(H - 1);
`endif
        byteQ.delete(); expQ.delete();
        reqMode = 1;
        applyStimulus_vsync();
        for (int n = 0; n < H + 1; n++) begin
            fillLine(1);
            applyStimulus_line(1'b0, W);
            if (n < H) pushExpected(n);
        end
        waitBytes(H * LEN, 1'b1, ok);
        repeat (20) tick();
        checks++;
        if (startCount - s0 !== H) begin failures++; $display("[TB] FAIL saturate_packets got %0d required %0d", startCount - s0, H); end
        checks++;
        if (!ok || byteQ.size() !== expQ.size()) begin failures++; $display("[TB] FAIL saturate_count got %0d required %0d", byteQ.size(), expQ.size()); end
        foreach (expQ[i]) if (i < byteQ.size()) begin
            checks++;
            if (byteQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL saturate_byte%0d got %02h required %02h", i, byteQ[i], expQ[i]); end
        end
        if (byteQ.size() >= H * LEN) begin
            checks++;
            if ({byteQ[(H-1)*LEN], byteQ[(H-1)*LEN+1]} !== hdrLast) begin
                failures++;
                $display("[TB] FAIL last_line_hdr got %04h required %04h", {byteQ[(H-1)*LEN], byteQ[(H-1)*LEN+1]}, hdrLast);
            end
            checks++;
            if ({byteQ[(H-2)*LEN], byteQ[(H-2)*LEN+1]} !== 16'(H - 2)) begin
                failures++;
                $display("[TB] FAIL prev_line_hdr got %04h required %04h", {byteQ[(H-2)*LEN], byteQ[(H-2)*LEN+1]}, 16'(H - 2));
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        bit ok;
        int d0;
        int s0;
        byteQ.delete(); expQ.delete();
        reqMode = 1;
        applyStimulus_vsync();
        fillLine(0);
        applyStimulus_line(1'b0, W);
        waitBytes(3, 1'b0, ok);
        reqMode = 0;
        tick();
        tick();
        d0 = doneCount;
        rst_p = 1'b1;
        #1;
        checks++;
        if ({tx_start, tx_done, overflow, tx_data} !== 11'b0) begin
            failures++;
            $display("[TB] FAIL midreset_outputs got %b required 0", {tx_start, tx_done, overflow, tx_data});
        end
        tick();
        tick();
        rst_p = 1'b0;
        s0 = startCount;
        reqMode = 1;
        repeat (10) tick();
        checks++;
        if (doneCount !== d0 || startCount !== s0) begin
            failures++;
            $display("[TB] FAIL midreset_abort got done=%0d start=%0d required done=%0d start=%0d", doneCount, startCount, d0, s0);
        end
        byteQ.delete(); expQ.delete();
        applyStimulus_vsync();
        fillLine(1);
        applyStimulus_line(1'b1, W);
        pushExpected(0);
        waitBytes(LEN, 1'b1, ok);
        checks++;
        if (!ok || byteQ.size() !== expQ.size()) begin failures++; $display("[TB] FAIL midreset_count got %0d required %0d", byteQ.size(), expQ.size()); end
        foreach (expQ[i]) if (i < byteQ.size()) begin
            checks++;
            if (byteQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL midreset_byte%0d got %02h required %02h", i, byteQ[i], expQ[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_req_toggle();
        test_random_lines();
        test_overflow();
        test_vsync_discard();
        test_frame_saturation();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sobel_line_scheduler.md
SOBEL_LINE_SCHEDULER -- requirements
Module: sobel_line_scheduler

Interface
REQ-001 Parameter IMAGE_WIDTH, default 1280: pixels per line; SHALL be a multiple of 8.
REQ-002 Parameter IMAGE_HEIGHT, default 720: lines per frame.
REQ-003 Parameter LINE_BYTES, default IMAGE_WIDTH/8: packed payload bytes per line.
REQ-004 Ports SHALL be:
- clk  in  1  single clock for all logic.
- rst_p  in  1  asynchronous, active-high reset.
- sobel_valid  in  1  pixel strobe.
- sobel_vsync  in  1  frame sync; a rising edge starts a frame.
- sobel  in  1  binary edge pixel.
- tx_ready  in  1  UDP sender idle.
- tx_req  in  1  byte pull from the UDP sender.
- tx_start  out  1  one-cycle packet-start pulse.
- tx_data  out  8  packet byte.
- tx_data_len  out  16  constant LINE_BYTES+2.
- tx_done  out  1  one-cycle pulse after the last byte is delivered.
- overflow  out  1  one-cycle pulse when a line is dropped.

Function
REQ-005 Packing SHALL be MSB-first: the first valid pixel of a byte goes to bit 7. Each 8th pixel SHALL write the byte to the active half of a 2 x LINE_BYTES ping-pong buffer.
REQ-006 The pixel counter SHALL advance only on sobel_valid. When it reaches IMAGE_WIDTH, the line SHALL be committed: the half is marked full, the write half toggles, and the pixel counter clears.
REQ-007 The line counter SHALL clear on a vsync rising edge and increment on each commit or drop. It SHALL saturate at IMAGE_HEIGHT-1. Pixels arriving after saturation SHALL be ignored until the next vsync.
REQ-008 A vsync rising edge SHALL discard any partial line without a commit or overflow. Full halves SHALL be kept.
REQ-009 If the first pixel of a line arrives while the write half is still full, the whole line SHALL be dropped. In that case: overflow pulses once on that pixel; the buffer is not written; the line number still increments.
REQ-010 The TX FSM SHALL have states IDLE, REQ, HDR_H, HDR_L, PAYLOAD, DONE.
REQ-011 IDLE -> REQ when the read half is full and tx_ready=1.
REQ-012 REQ SHALL drive tx_start=1 for exactly one cycle and then go to HDR_H.
REQ-013 In HDR_H, HDR_L and PAYLOAD, each cycle with tx_req=1 SHALL present the next byte on tx_data on the following cycle.
REQ-014 Byte order SHALL be: line number [15:8], line number [7:0], then payload bytes 0..LINE_BYTES-1.
REQ-015 tx_req=0 SHALL hold the state and tx_data.
REQ-016 After the last payload byte is presented, the FSM SHALL enter DONE. DONE SHALL pulse tx_done, clear that half's full flag, toggle the read half and return to IDLE.
REQ-017 The line number sent SHALL be latched at commit time into a per-half register.
REQ-018 If a commit and a DONE release hit the same half in the same cycle, the release SHALL be applied first. No line is lost.
REQ-019 tx_req outside HDR_H..PAYLOAD SHALL be ignored.
REQ-020 Worst-case latency from commit to tx_start SHALL be 2 cycles when the FSM is IDLE and tx_ready=1.

Reset
REQ-021 While rst_p=1, the following SHALL be 0: tx_start, tx_done, overflow, tx_data, all counters, full flags and both half pointers. FSM state SHALL be IDLE.
REQ-022 tx_data_len SHALL equal LINE_BYTES+2 at all times, including in reset.
REQ-023 Reset mid-packet SHALL abort the packet; no tx_done is issued.
REQ-024 After reset, the first frame SHALL begin only at the next vsync rising edge. Pixels before that edge are ignored.

Configuration
REQ-025 With macro FRAME_END_FLAG_EN defined, header bit 15 SHALL be 1 for line IMAGE_HEIGHT-1 and 0 otherwise. Line number bits [14:0] are unchanged.
REQ-026 Without FRAME_END_FLAG_EN, header bit 15 SHALL always be 0.

Verification
REQ-027 vsync edge, 1280 valid pixels alternating 1,0, tx_ready=1, tx_req held 1 -> tx_start; bytes 0x00,0x00, then 160 x 0xAA; tx_done; tx_data_len=162.
REQ-028 Two lines committed back-to-back with tx_ready=0, then third line starts -> overflow pulse on its first pixel; tx_ready=1 then yields packets for lines 0 and 1 only; next header carries 3.
REQ-029 tx_req toggling 1,0 during payload -> byte sequence identical to REQ-027; tx_data stable while tx_req=0.
REQ-030 vsync edge after 600 pixels of line 5 -> no packet for the partial line; next packet header = 0x0000.
REQ-031 rst_p asserted during PAYLOAD byte 50 -> all outputs 0 next cycle; no tx_done; a fresh frame after reset sends line 0 correctly.
REQ-032 FRAME_END_FLAG_EN defined, full 720-line frame -> line 719 header 0x82CF; line 718 header 0x02CE.
